// File: rtl/byteen_regfile.sv
// byteen_regfile: DEPTH x (8*NUM_BYTES) register bank with per-byte write
// enables, a registered read port and a sequenced bulk-clear engine.
//
// Optional feature, enabled by defining BYTEEN_REGFILE_BYPASS_EN:
//   same-cycle read and write of one entry returns the merged (post-write)
//   word. Without the macro the read returns the stored (pre-write) word
//   and no forwarding logic is built.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | normal operation; reads and writes accepted
// CLEAR | zeroing entry[ptr] each cycle; busy=1, reads/writes ignored
module byteen_regfile #(
  parameter int NUM_BYTES = 2,
  parameter int DEPTH     = 8,
  localparam int AW       = $clog2(DEPTH),
  localparam int DW       = 8 * NUM_BYTES
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clr_req,
  output logic                 busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [NUM_BYTES-1:0] byteena,
  input  logic [DW-1:0]        wr_data,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic [DW-1:0]        rd_data,
  output logic                 rd_valid
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state, state_nxt;
  logic [AW-1:0] ptr;
  logic          last_entry;
  logic          wr_acc;
  logic          rd_acc;
  logic          rd_in_range;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] mem [DEPTH];

  assign last_entry  = (ptr == AW'(DEPTH - 1));
  // A clear request in the same cycle wins over a write; the write is dropped.
  assign wr_acc      = wr_en && !busy && !clr_req && ({1'b0, wr_addr} < DEPTH_W);
  assign rd_acc      = rd_en && !busy;
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

  // State register and clear pointer; pointer parks at 0 outside CLEAR.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) ptr <= ptr + 1'b1;
      else                ptr <= '0;
    end
  end

  // Next-state: a request in IDLE starts a sweep; it ends after the last entry.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req)    state_nxt = CLEAR;
      CLEAR:   if (last_entry) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state: busy covers exactly the DEPTH sweep cycles.
  always_comb begin
    busy = 1'b0;
    if (state == CLEAR) busy = 1'b1;
  end

  // Storage: sweep zeroes entry[ptr]; accepted writes update enabled lanes only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (busy && (ptr == AW'(e))) begin
          mem[e] <= '0;
        end else if (wr_acc && (wr_addr == AW'(e))) begin
          for (int b = 0; b < NUM_BYTES; b++)
            if (byteena[b]) mem[e][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read word selection; out-of-range addresses read as zero.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) rd_word = mem[rd_addr];
`ifdef BYTEEN_REGFILE_BYPASS_EN
    if (wr_acc && (wr_addr == rd_addr)) begin
      for (int b = 0; b < NUM_BYTES; b++)
        if (byteena[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
    end
`endif
  end

  // Registered read port: data holds between reads, valid pulses per read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_byteen_regfile.sv
// Testbench for byteen_regfile (NUM_BYTES=2, DEPTH=8): directed scenarios
// plus a randomized read/write run checked against an array model.
module tb_byteen_regfile;

  localparam int NB = 2;
  localparam int DP = 8;
  localparam int AW = 3;
  localparam int DW = 16;

  logic          clk;
  logic          resetn;
  logic          clr_req;
  logic          busy;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [NB-1:0] byteena;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  logic [DW-1:0] model [DP];
  int n_cmp;
  int n_fail;

  byteen_regfile #(.NUM_BYTES(NB), .DEPTH(DP)) dut (
    .clk(clk), .resetn(resetn), .clr_req(clr_req), .busy(busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .byteena(byteena), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] mask;
    mask = '0;
    for (int i = 0; i < NB; i++) if (be[i]) mask[8*i +: 8] = 8'hFF;
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [NB-1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; byteena = be;
    step();
    wr_en = 1'b0;
    model[a] = merge(model[a], d, be);
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                         output logic v);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
    d = rd_data;
    v = rd_valid;
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    logic v;
    resetn = 1'b0;
    #3;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    n_cmp++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data); end
    step();
    resetn = 1'b1;
    for (int i = 0; i < DP; i++) model[i] = '0;
    step();
    do_read(3'd5, d, v);
    n_cmp++; if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_read_data got=%h exp=0000", d); end
    n_cmp++; if (v !== 1'b1) begin n_fail++; $display("FAIL reset_read_valid got=%b exp=1", v); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_read_busy got=%b exp=0", busy); end
    step();
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL valid_pulse got=%b exp=0", rd_valid); end
  endtask

  task automatic test_partial_merge();
    logic [DW-1:0] d;
    logic v;
    do_write(3'd3, 16'hABCD, 2'b11);
    do_write(3'd3, 16'h1234, 2'b01);
    do_read(3'd3, d, v);
    n_cmp++; if (d !== 16'hAB34) begin n_fail++; $display("FAIL merge_lo got=%h exp=ab34", d); end
    n_cmp++; if (v !== 1'b1) begin n_fail++; $display("FAIL merge_valid got=%b exp=1", v); end
    do_write(3'd3, 16'hFFFF, 2'b00);
    do_read(3'd3, d, v);
    n_cmp++; if (d !== 16'hAB34) begin n_fail++; $display("FAIL merge_be00 got=%h exp=ab34", d); end
    do_write(3'd3, 16'h9900, 2'b10);
    do_read(3'd3, d, v);
    n_cmp++; if (d !== 16'h9934) begin n_fail++; $display("FAIL merge_hi got=%h exp=9934", d); end
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] d;
    logic [DW-1:0] exp_d;
    logic v;
    do_write(3'd2, 16'h5566, 2'b11);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h7788; byteena = 2'b10;
    rd_en = 1'b1; rd_addr = 3'd2;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    model[2] = merge(model[2], 16'h7788, 2'b10);
`ifdef BYTEEN_REGFILE_BYPASS_EN
    exp_d = 16'h7766;
`else
    exp_d = 16'h5566;
`endif
    n_cmp++; if (rd_data !== exp_d) begin n_fail++; $display("FAIL same_cycle got=%h exp=%h", rd_data, exp_d); end
    n_cmp++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL same_cycle_valid got=%b exp=1", rd_valid); end
    do_read(3'd2, d, v);
    n_cmp++; if (d !== 16'h7766) begin n_fail++; $display("FAIL same_cycle_after got=%h exp=7766", d); end
  endtask

  task automatic test_clear();
    logic [DW-1:0] d;
    logic v;
    int cnt;
    for (int i = 0; i < DP; i++) do_write(AW'(i), DW'($urandom) | 16'h0101, 2'b11);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      cnt++;
      wr_en = 1'b1; wr_addr = AW'($urandom); wr_data = DW'($urandom); byteena = 2'b11;
      rd_en = 1'b1; rd_addr = AW'($urandom);
      step();
      n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL clear_rd_valid cyc=%0d got=%b exp=0", cnt, rd_valid); end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    n_cmp++; if (cnt != DP) begin n_fail++; $display("FAIL clear_busy_len got=%0d exp=%0d", cnt, DP); end
    for (int i = 0; i < DP; i++) model[i] = '0;
    for (int i = 0; i < DP; i++) begin
      do_read(AW'(i), d, v);
      n_cmp++; if (d !== model[i] || v !== 1'b1) begin n_fail++; $display("FAIL clear_entry%0d got=%h/%b exp=%h/1", i, d, v, model[i]); end
    end
  endtask

  task automatic test_clear_collision();
    logic [DW-1:0] d;
    logic v;
    int cnt;
    do_write(3'd0, 16'h1234, 2'b11);
    do_write(3'd5, 16'h4321, 2'b11);
    clr_req = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF; byteena = 2'b11;
    rd_en = 1'b1; rd_addr = 3'd0;
    step();
    clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    n_cmp++; if (rd_data !== 16'h1234 || rd_valid !== 1'b1) begin n_fail++; $display("FAIL clr_rd_preclear got=%h/%b exp=1234/1", rd_data, rd_valid); end
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      cnt++;
      clr_req = (cnt == 3);
      step();
      clr_req = 1'b0;
    end
    n_cmp++; if (cnt != DP) begin n_fail++; $display("FAIL clr_collide_busy_len got=%0d exp=%0d", cnt, DP); end
    for (int i = 0; i < DP; i++) model[i] = '0;
    do_read(3'd0, d, v);
    n_cmp++; if (d !== 16'h0000) begin n_fail++; $display("FAIL clr_collide_addr0 got=%h exp=0000", d); end
    do_read(3'd5, d, v);
    n_cmp++; if (d !== 16'h0000) begin n_fail++; $display("FAIL clr_collide_addr5 got=%h exp=0000", d); end
  endtask

  task automatic test_reset_mid_clear();
    logic [DW-1:0] d;
    logic v;
    for (int i = 0; i < DP; i++) do_write(AW'(i), 16'hA5A5 ^ DW'(i), 2'b11);
    do_read(3'd6, d, v);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step(); step(); step();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midclr_busy_before got=%b exp=1", busy); end
    resetn = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midclr_busy got=%b exp=0", busy); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL midclr_valid got=%b exp=0", rd_valid); end
    n_cmp++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL midclr_rd_data got=%h exp=0000", rd_data); end
    step();
    resetn = 1'b1;
    for (int i = 0; i < DP; i++) model[i] = '0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midclr_busy_release got=%b exp=0", busy); end
    do_write(3'd7, 16'h0F0F, 2'b11);
    do_read(3'd7, d, v);
    n_cmp++; if (d !== 16'h0F0F || v !== 1'b1) begin n_fail++; $display("FAIL midclr_wr_rd got=%h/%b exp=0f0f/1", d, v); end
    for (int i = 4; i < DP - 1; i++) begin
      do_read(AW'(i), d, v);
      n_cmp++; if (d !== 16'h0000) begin n_fail++; $display("FAIL midclr_entry%0d got=%h exp=0000", i, d); end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_d;
    logic          we, re;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    logic [NB-1:0] be;
    exp_d = rd_data;
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wa = AW'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      wd = DW'($urandom);
      be = NB'($urandom);
      wr_en = we; wr_addr = wa; wr_data = wd; byteena = be;
      rd_en = re; rd_addr = ra;
      if (re) begin
        exp_d = model[ra];
`ifdef BYTEEN_REGFILE_BYPASS_EN
        if (we && wa == ra) exp_d = merge(model[ra], wd, be);
`endif
      end
      if (we) model[wa] = merge(model[wa], wd, be);
      step();
      n_cmp++; if (rd_valid !== re) begin n_fail++; $display("FAIL rand_valid n=%0d got=%b exp=%b", n, rd_valid, re); end
      n_cmp++; if (rd_data !== exp_d) begin n_fail++; $display("FAIL rand_data n=%0d addr=%0d got=%h exp=%h", n, ra, rd_data, exp_d); end
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    resetn = 1'b0; clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; byteena = '0; wr_data = '0;
    for (int i = 0; i < DP; i++) model[i] = '0;
    test_reset();
    test_partial_merge();
    test_same_cycle();
    test_clear();
    test_clear_collision();
    test_reset_mid_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/byteen_regfile.md
Name: byteen_regfile

Overview:
- Parametrised multi-entry register bank with per-byte write enables; the next generation of the team's 16-bit byte-enabled register.
- Generalised to NUM_BYTES lanes and DEPTH entries, with a registered read port and a sequenced bulk-clear engine.
- Disabled lanes retain their old value; they are never zeroed.
- Used as a small configuration/scratch store beside datapath blocks.

Parameters:
- NUM_BYTES, 2, number of byte lanes; data width is 8*NUM_BYTES.
- DEPTH, 8, number of entries; must be >= 2. AW = $clog2(DEPTH) is a derived localparam.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- clr_req  in  1  single-cycle request to zero all entries
- busy  out  1  high while the clear sequence runs
- wr_en  in  1  write strobe
- wr_addr  in  AW  write entry index
- byteena  in  NUM_BYTES  per-lane write enable; bit i covers wr_data[8i+7:8i]
- wr_data  in  8*NUM_BYTES  write data
- rd_en  in  1  read strobe
- rd_addr  in  AW  read entry index
- rd_data  out  8*NUM_BYTES  registered read data
- rd_valid  out  1  one-cycle pulse, aligned with new rd_data

Behaviour:
- Reset (resetn low, asynchronous):
  - all entries, rd_data, rd_valid, busy and the clear pointer go to 0
  - state = IDLE
  - takes effect immediately, including mid-clear; the sequence is abandoned.
- Write:
  - At a posedge with wr_en=1, busy=0 and no clr_req, each lane with byteena[i]=1 takes the new byte.
  - Lanes with byteena[i]=0 hold.
  - byteena all zero means no change.
- Read:
  - At a posedge with rd_en=1 and busy=0, rd_data <= entry[rd_addr] and rd_valid <= 1.
  - Latency is 1 cycle.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
- Out-of-range address (DEPTH not a power of two):
  - a write to addr >= DEPTH is dropped
  - a read from addr >= DEPTH returns 0 with rd_valid=1.
- Same-cycle read and write to the same address:
  - returns the pre-write contents (see the optional feature).
- Writes to different addresses never affect a concurrent read.
- State machine IDLE / CLEAR:
  - IDLE, with clr_req=1 sampled at edge T: go to CLEAR, busy=1, ptr=0.
  - CLEAR, at edges T+1..T+DEPTH: entry[ptr] <= 0, ptr++.
  - At edge T+DEPTH (last entry cleared): go to IDLE, busy=0. busy is therefore high for exactly DEPTH cycles.
- Simultaneous and in-clear events:
  - clr_req with wr_en in IDLE: clear wins and the write is dropped.
  - clr_req with rd_en in IDLE: the read is serviced with pre-clear data.
  - clr_req while busy: ignored (no restart, no extension).
  - wr_en/rd_en while busy: ignored; rd_valid stays 0.

Optional Feature:
- BYTEEN_REGFILE_BYPASS_EN defined:
  - On a same-cycle rd_en and accepted wr_en with rd_addr==wr_addr, rd_data returns the merged value.
  - Lanes with byteena=1 come from wr_data; the rest come from the stored entry.
- Not defined:
  - The read returns the old stored value.
  - No forwarding logic is present.

Test Plan (NUM_BYTES=2, DEPTH=8):
- Reset then read:
  - Stimulus: assert resetn=0, release, then read addr 5.
  - Required: rd_data=16'h0000 with rd_valid=1 one cycle after rd_en; busy=0.
- Partial write merge:
  - Stimulus: write addr 3 data 16'hABCD byteena=2'b11, then write 16'h1234 byteena=2'b01, then read addr 3.
  - Required: 16'hAB34. A further write with byteena=2'b00 leaves 16'hAB34.
- Same-cycle read/write:
  - Stimulus: addr 2 holds 16'h5566; in one cycle write 16'h7788 byteena=2'b10 and read addr 2.
  - Required: 16'h5566 without the macro; 16'h7766 with BYTEEN_REGFILE_BYPASS_EN. A subsequent read returns 16'h7766 in both builds.
- Clear sequence:
  - Stimulus: fill all 8 entries with nonzero data, pulse clr_req for 1 cycle.
  - Required: busy high for exactly 8 cycles. Reads/writes issued during busy produce no rd_valid and no change. Afterwards every entry reads 16'h0000.
- Clear collisions:
  - Stimulus: clr_req in the same cycle as a write of 16'hFFFF to addr 0; second clr_req mid-clear.
  - Required: addr 0 reads 0 after the clear; busy still lasts 8 cycles total.
- Reset mid-clear:
  - Stimulus: drop resetn at cycle 4 of CLEAR.
  - Required: busy=0, rd_valid=0 and entries=0 immediately (asynchronous). After release, a write/read of 16'h0F0F to addr 7 works on the next cycle.
